// File: rtl/int_to_fp_seq.sv
// rtl/int_to_fp_seq.sv - sequential signed-integer to {sign, exp, frac} converter, one shift per cycle.
// Optional build macro ROUND_NEAREST_EN: round-to-nearest-even on dropped bits when FRAC_W < INT_W.
module int_to_fp_seq #(
    parameter int INT_W  = 8,
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INT_W-1:0]        int_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   fp_out
);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic               sign;
    logic [INT_W-1:0]   mag;
    logic [EXP_W-1:0]   exp_cnt;
    logic [FRAC_W-1:0]  frac_norm;
    logic [EXP_W-1:0]   exp_norm;
    logic               mag_zero;
    logic               mag_top;

    assign mag_zero = (mag == '0);
    assign mag_top  = mag[INT_W-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = NORM;
            NORM:    if (mag_zero || mag_top) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Negating the most negative operand wraps to 2**(INT_W-1), which is the correct magnitude.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign    <= 1'b0;
            mag     <= '0;
            exp_cnt <= '0;
            fp_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign    <= int_in[INT_W-1];
                        mag     <= int_in[INT_W-1] ? -int_in : int_in;
                        exp_cnt <= EXP_W'(INT_W);
                    end
                end
                NORM: begin
                    if (mag_zero) begin
                        fp_out <= '0;
                    end else if (mag_top) begin
                        fp_out <= {sign, exp_norm, frac_norm};
                    end else begin
                        mag     <= mag << 1;
                        exp_cnt <= exp_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        if (FRAC_W >= INT_W) begin : g_wide
            logic [FRAC_W-1:0] mag_ext;
            assign mag_ext   = FRAC_W'(mag);
            assign frac_norm = mag_ext << (FRAC_W - INT_W);
            assign exp_norm  = exp_cnt;
        end else begin : g_narrow
            logic [FRAC_W-1:0] frac_trunc;
            assign frac_trunc = mag[INT_W-1 -: FRAC_W];
`ifdef ROUND_NEAREST_EN
            localparam int DROP = INT_W - FRAC_W;
            localparam logic [INT_W-1:0] STICKY_MASK = (INT_W'(1) << (DROP - 1)) - INT_W'(1);
            logic              guard;
            logic              sticky;
            logic              round_up;
            logic [FRAC_W:0]   frac_sum;
            assign guard    = mag[DROP-1];
            assign sticky   = |(mag & STICKY_MASK);
            assign round_up = guard & (sticky | frac_trunc[0]);
            assign frac_sum = {1'b0, frac_trunc} + (FRAC_W+1)'(round_up);
            // A carry out of the fraction renormalises to 1.000.. with the exponent bumped.
            assign frac_norm = frac_sum[FRAC_W] ? (FRAC_W'(1) << (FRAC_W - 1)) : frac_sum[FRAC_W-1:0];
            assign exp_norm  = exp_cnt + EXP_W'(frac_sum[FRAC_W]);
`else
            assign frac_norm = frac_trunc;
            assign exp_norm  = exp_cnt;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_int_to_fp_seq.sv
// tb/tb_int_to_fp_seq.sv - self-checking bench for int_to_fp_seq (default and FRAC_W=4 instances).
module tb_int_to_fp_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [7:0]  int_in;
    logic        out_ready;
    logic        in_ready;
    logic        out_valid;
    logic [12:0] fp_out;
    logic        in_ready4;
    logic        out_valid4;
    logic [8:0]  fp_out4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_to_fp_seq #(.INT_W(8), .EXP_W(4), .FRAC_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .int_in(int_in), .out_valid(out_valid), .out_ready(out_ready), .fp_out(fp_out)
    );

    int_to_fp_seq #(.INT_W(8), .EXP_W(4), .FRAC_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
        .int_in(int_in), .out_valid(out_valid4), .out_ready(out_ready), .fp_out(fp_out4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: find the leading one arithmetically, scale, then round on the remainder.
    function automatic logic [31:0] ref_fp(input logic [7:0] x, input int fw);
        int m, p, e, f, d;
        logic s;
        s = x[7];
        m = s ? 256 - int'(x) : int'(x);
        if (m == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 8; i++) if (m >= (1 << i)) p = i;
        e = p + 1;
        if (fw - 1 >= p) begin
            f = m << (fw - 1 - p);
        end else begin
            d = p - (fw - 1);
            f = m >> d;
`ifdef ROUND_NEAREST_EN
            begin
                int rem, half;
                rem  = m - (f << d);
                half = 1 << (d - 1);
                if (rem > half || (rem == half && (f % 2) == 1)) f++;
                if (f == (1 << fw)) begin
                    f = f >> 1;
                    e++;
                end
            end
`endif
        end
        return (32'(s) << (4 + fw)) | (32'(e) << fw) | 32'(f);
    endfunction

    function automatic int ref_lat(input logic [7:0] x);
        int m, p;
        m = x[7] ? 256 - int'(x) : int'(x);
        if (m == 0) return 2;
        p = 0;
        for (int i = 0; i < 8; i++) if (m >= (1 << i)) p = i;
        return (7 - p) + 2;
    endfunction

    // lat counts cycles from the accept cycle to the first cycle with out_valid high.
    task automatic run_op(input logic [7:0] x, input bit hold, output int lat);
        @(negedge clk);
        int_in    = x;
        in_valid  = 1'b1;
        out_ready = !hold;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            if (lat == 0) in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic do_vec(input string tag, input logic [7:0] x, input logic [12:0] exp13,
                          input logic [8:0] exp9);
        int lat;
        run_op(x, 1'b0, lat);
        check({tag, "_fp"}, 32'(fp_out), 32'(exp13));
        check({tag, "_fp4"}, 32'(fp_out4), 32'(exp9));
        check({tag, "_lat"}, 32'(lat), 32'(ref_lat(x)));
        check({tag, "_v4"}, 32'(out_valid4), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_drop"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int lat, t1, t2, seen;
        logic [7:0] r;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        int_in    = 8'h00;
        out_ready = 1'b1;
        #12;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_fp", 32'(fp_out), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        do_vec("v01", 8'h01, 13'h0180, 9'(ref_fp(8'h01, 4)));
        do_vec("v80", 8'h80, 13'h1880, 9'(ref_fp(8'h80, 4)));
        do_vec("v64", 8'h64, 13'h07C8, 9'(ref_fp(8'h64, 4)));
        do_vec("v9c", 8'h9C, 13'h17C8, 9'(ref_fp(8'h9C, 4)));
        do_vec("v00", 8'h00, 13'h0000, 9'h000);
`ifdef ROUND_NEAREST_EN
        do_vec("v5d", 8'h5D, 13'(ref_fp(8'h5D, 8)), 9'h07C);
        do_vec("v7c", 8'h7C, 13'(ref_fp(8'h7C, 8)), 9'h088);
`else
        do_vec("v5d", 8'h5D, 13'(ref_fp(8'h5D, 8)), 9'h07B);
        do_vec("v7c", 8'h7C, 13'(ref_fp(8'h7C, 8)), 9'h07F);
`endif

        // Backpressure: result held, input side closed, in_valid pulses ignored.
        run_op(8'h64, 1'b1, lat);
        check("bp_lat", 32'(lat), 32'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            int_in   = 8'h01;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_fp", 32'(fp_out), 32'h07C8);
            check("bp_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {30'd0, out_valid, in_ready}, 32'b01);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("bp_no_accept", 32'(seen), 32'd0);

        // Reset in the middle of normalisation.
        @(negedge clk);
        int_in   = 8'h01;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_fp", 32'(fp_out), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        do_vec("post_rst", 8'h01, 13'h0180, 9'(ref_fp(8'h01, 4)));

        // Throughput with in_valid and out_ready held: one result per L+1 cycles.
        @(negedge clk);
        int_in    = 8'h80;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        t1 = -1;
        t2 = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid && t1 < 0) t1 = k;
            else if (out_valid && t2 < 0) t2 = k;
        end
        in_valid = 1'b0;
        check("tput_period", 32'(t2 - t1), 32'd3);
        repeat (4) @(posedge clk);

        for (int k = 0; k < 40; k++) begin
            r = 8'($urandom_range(0, 255));
            do_vec("rnd", r, 13'(ref_fp(r, 8)), 9'(ref_fp(r, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
